cpu_seq_ctrl: RTL and testbench

Multi-cycle instruction sequencer for the 16-bit CPU datapath: instruction ROM, PC, instruction splitter, register file, Op1/Op2 latches, ALU and data RAM. It drives their load/increment strobes through fetch, decode, optional extension-word fetch, optional RAM read, operand load, execute and write-back. It replaces the free-running control-signal generator. It adds halt/illegal-instruction detection and a retired-instruction counter.

---
 rtl/cpu_seq_ctrl.sv | 151 +++++++++++++++
 tb/tb_cpu_seq_ctrl.sv | 189 ++++++++++++++++++
 2 files changed

// File: rtl/cpu_seq_ctrl.sv
// Multi-cycle instruction sequencer for the 16-bit CPU datapath.
// Drives the fetch/decode/operand/execute/write-back strobes and tracks halt, illegal and retired count.
module cpu_seq_ctrl #(
  parameter int          RAM_LAT  = 2,
  parameter int          CNT_W    = 16,
  parameter logic [3:0]  HALT_OPC = 4'hF,
  parameter logic [3:0]  CMP_OPC  = 4'hC
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             en,
  input  logic [1:0]       ins_byte,
  input  logic [1:0]       ins_mode,
  input  logic [1:0]       ins_ot,
  input  logic [3:0]       ins_opcode,
  output logic             ins_load,
  output logic             ext_load,
  output logic             pc_inc,
  output logic             ram_rd,
  output logic             op1_load,
  output logic             op2_load,
  output logic             alu_go,
  output logic             reg_load,
  output logic             busy,
  output logic             halted,
  output logic             illegal,
  output logic [3:0]       state,
  output logic [CNT_W-1:0] instr_count
);

  localparam logic [3:0] S_IDLE   = 4'd0;
  localparam logic [3:0] S_FETCH  = 4'd1;
  localparam logic [3:0] S_DECODE = 4'd2;
  localparam logic [3:0] S_EXT    = 4'd3;
  localparam logic [3:0] S_MEMRD  = 4'd4;
  localparam logic [3:0] S_OPLD   = 4'd5;
  localparam logic [3:0] S_EXEC   = 4'd6;
  localparam logic [3:0] S_WB     = 4'd7;
  localparam logic [3:0] S_RETIRE = 4'd8;
  localparam logic [3:0] S_HALT   = 4'd9;

  logic [3:0] next_state;
  logic [3:0] lat_cnt;
  logic [1:0] mode_q;
  logic [1:0] ot_q;
  logic [3:0] opc_q;
  logic       bad_enc;
  logic       illegal_det;
  logic       legal_halt;

  // Any encoding the datapath cannot sequence halts the CPU rather than running garbage.
  assign bad_enc = (ins_mode == 2'b11) ||
                   !((ins_byte == 2'b01) || (ins_byte == 2'b10)) ||
                   ((ins_ot == 2'b11) && (ins_opcode != HALT_OPC)) ||
                   ((ins_mode != 2'b00) && (ins_byte != 2'b10));

  always_comb begin
    next_state  = state;
    illegal_det = 1'b0;
    legal_halt  = 1'b0;
    case (state)
      S_IDLE:   if (en) next_state = S_FETCH;
      S_FETCH:  next_state = S_DECODE;
      S_DECODE: begin
        if (bad_enc) begin
          next_state  = S_HALT;
          illegal_det = 1'b1;
        end else if (ins_ot == 2'b11) begin
          next_state = S_HALT;
          legal_halt = 1'b1;
        end else if (ins_byte == 2'b10) begin
          next_state = S_EXT;
        end else begin
          next_state = S_OPLD;
        end
      end
      S_EXT:    next_state = (mode_q == 2'b10) ? S_MEMRD : S_OPLD;
      S_MEMRD:  if (lat_cnt == 4'd0) next_state = S_OPLD;
      S_OPLD:   next_state = S_EXEC;
      S_EXEC:   next_state = ((ot_q == 2'b01) && (opc_q == CMP_OPC)) ? S_RETIRE : S_WB;
      S_WB:     next_state = S_RETIRE;
      S_RETIRE: next_state = en ? S_FETCH : S_IDLE;
      S_HALT:   next_state = S_HALT;
      default:  next_state = S_IDLE;
    endcase
  end

  // Strobes are decoded from the next state so they flop in step with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= S_IDLE;
      ins_load <= 1'b0;
      ext_load <= 1'b0;
      pc_inc   <= 1'b0;
      ram_rd   <= 1'b0;
      op1_load <= 1'b0;
      op2_load <= 1'b0;
      alu_go   <= 1'b0;
      reg_load <= 1'b0;
      busy     <= 1'b0;
      halted   <= 1'b0;
      illegal  <= 1'b0;
    end else begin
      state    <= next_state;
      ins_load <= (next_state == S_FETCH);
      ext_load <= (next_state == S_EXT);
      pc_inc   <= (next_state == S_DECODE) || (next_state == S_EXT);
      ram_rd   <= (next_state == S_MEMRD);
      op1_load <= (next_state == S_OPLD);
      op2_load <= (next_state == S_OPLD);
      alu_go   <= (next_state == S_EXEC);
      reg_load <= (next_state == S_WB);
      busy     <= (next_state != S_IDLE) && (next_state != S_HALT);
      halted   <= halted || (next_state == S_HALT);
      illegal  <= illegal || illegal_det;
    end
  end

  // Later states must not see the splitter change under them, so fields are held from DECODE.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mode_q <= 2'b00;
      ot_q   <= 2'b00;
      opc_q  <= 4'h0;
    end else if (state == S_DECODE) begin
      mode_q <= ins_mode;
      ot_q   <= ins_ot;
      opc_q  <= ins_opcode;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lat_cnt <= 4'd0;
    end else if (state == S_EXT) begin
      lat_cnt <= 4'(RAM_LAT - 1);
    end else if ((state == S_MEMRD) && (lat_cnt != 4'd0)) begin
      lat_cnt <= lat_cnt - 4'd1;
    end
  end

  // A legal HALT counts as retired at the moment it is decoded.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      instr_count <= '0;
    end else if ((state == S_RETIRE) || legal_halt) begin
      instr_count <= instr_count + CNT_W'(1);
    end
  end

endmodule

// File: tb/tb_cpu_seq_ctrl.sv
// Randomized bench for cpu_seq_ctrl: a per-instruction expected state list is built from the
// sequencing rules and compared cycle by cycle against state, strobes and retired count.
module tb_cpu_seq_ctrl;

  localparam int RAM_LAT = 2;
  localparam int CNT_W   = 4;

  localparam int S_IDLE = 0, S_FETCH = 1, S_DECODE = 2, S_EXT = 3, S_MEMRD = 4;
  localparam int S_OPLD = 5, S_EXEC = 6, S_WB = 7, S_RETIRE = 8, S_HALT = 9;

  logic             clk = 1'b0;
  logic             rst_n = 1'b1;
  logic             en = 1'b0;
  logic [1:0]       ins_byte = 2'b00;
  logic [1:0]       ins_mode = 2'b00;
  logic [1:0]       ins_ot = 2'b00;
  logic [3:0]       ins_opcode = 4'h0;
  logic             ins_load, ext_load, pc_inc, ram_rd, op1_load, op2_load;
  logic             alu_go, reg_load, busy, halted, illegal;
  logic [3:0]       state;
  logic [CNT_W-1:0] instr_count;

  int checks = 0;
  int failures = 0;
  int model_count = 0;
  int prev_state = S_IDLE;

  cpu_seq_ctrl #(.RAM_LAT(RAM_LAT), .CNT_W(CNT_W), .HALT_OPC(4'hF), .CMP_OPC(4'hC)) dut (
    .clk(clk), .rst_n(rst_n), .en(en),
    .ins_byte(ins_byte), .ins_mode(ins_mode), .ins_ot(ins_ot), .ins_opcode(ins_opcode),
    .ins_load(ins_load), .ext_load(ext_load), .pc_inc(pc_inc), .ram_rd(ram_rd),
    .op1_load(op1_load), .op2_load(op2_load), .alu_go(alu_go), .reg_load(reg_load),
    .busy(busy), .halted(halted), .illegal(illegal), .state(state), .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  wire [10:0] obs_vec = {ins_load, ext_load, pc_inc, ram_rd, op1_load, op2_load,
                         alu_go, reg_load, busy, halted, illegal};

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Strobe set each state is defined to show, as {ins,ext,pc,ram,op1,op2,alu,reg,busy,halted,illegal}.
  function automatic logic [10:0] exp_vec(input int s, input bit ill);
    case (s)
      S_FETCH:  return 11'b10000000100;
      S_DECODE: return 11'b00100000100;
      S_EXT:    return 11'b01100000100;
      S_MEMRD:  return 11'b00010000100;
      S_OPLD:   return 11'b00001100100;
      S_EXEC:   return 11'b00000010100;
      S_WB:     return 11'b00000001100;
      S_RETIRE: return 11'b00000000100;
      S_HALT:   return {10'b0000000001, ill};
      default:  return 11'b0;
    endcase
  endfunction

  task automatic applyStimulus(input int exp_state, input bit ill, input bit en_val,
                               input logic [1:0] b, input logic [1:0] m, input logic [1:0] o,
                               input logic [3:0] c);
    @(negedge clk);
    en = en_val;
    if (prev_state == S_DECODE) begin
      {ins_byte, ins_mode, ins_ot, ins_opcode} = {b, m, o, c};
    end else begin
      {ins_byte, ins_mode, ins_ot, ins_opcode} = 10'($urandom);
    end
    @(posedge clk);
    #1;
    if (prev_state == S_RETIRE || (exp_state == S_HALT && prev_state == S_DECODE && !ill))
      model_count++;
    checkOutput("state", 32'(state), 32'(exp_state));
    checkOutput("strobes", 32'(obs_vec), 32'(exp_vec(exp_state, ill)));
    checkOutput("instr_count", 32'(instr_count), 32'(model_count % (1 << CNT_W)));
    prev_state = exp_state;
  endtask

  task automatic resetCheck();
    en = 1'b0;
    rst_n = 1'b0;
    model_count = 0;
    #1;
    checkOutput("rst_state", 32'(state), 32'(S_IDLE));
    checkOutput("rst_strobes", 32'(obs_vec), 32'h0);
    checkOutput("rst_count", 32'(instr_count), 32'(0));
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    prev_state = S_IDLE;
  endtask

  task automatic doReset();
    @(posedge clk);
    #3;
    resetCheck();
  endtask

  task automatic run_instr(input logic [1:0] b, input logic [1:0] m, input logic [1:0] o,
                           input logic [3:0] c, input bit en_end, input bit abort_exec);
    int  q[$];
    bit  ill;
    bit  halt;
    bit  en_val;
    int  pc_seen;
    pc_seen = 0;
    ill  = (m == 2'b11) || !(b == 2'b01 || b == 2'b10) || (o == 2'b11 && c != 4'hF) ||
           (m != 2'b00 && b != 2'b10);
    halt = ill || (o == 2'b11);
    q.push_back(S_FETCH);
    q.push_back(S_DECODE);
    if (halt) begin
      q.push_back(S_HALT);
    end else begin
      if (b == 2'b10) q.push_back(S_EXT);
      if (m == 2'b10) for (int k = 0; k < RAM_LAT; k++) q.push_back(S_MEMRD);
      q.push_back(S_OPLD);
      q.push_back(S_EXEC);
      if (!(o == 2'b01 && c == 4'hC)) q.push_back(S_WB);
      q.push_back(S_RETIRE);
    end
    foreach (q[i]) begin
      en_val = (prev_state == S_IDLE || prev_state == S_RETIRE) ? 1'b1 : 1'($urandom);
      applyStimulus(q[i], ill, en_val, b, m, o, c);
      pc_seen += int'(pc_inc);
      if (abort_exec && q[i] == S_EXEC) begin
        #2;
        resetCheck();
        return;
      end
    end
    checkOutput("pc_inc_count", 32'(pc_seen), 32'((!halt && b == 2'b10) ? 2 : 1));
    if (halt) begin
      for (int k = 0; k < 4; k++) applyStimulus(S_HALT, ill, 1'($urandom), b, m, o, c);
    end else if (!en_end) begin
      applyStimulus(S_IDLE, 1'b0, 1'b0, b, m, o, c);
      applyStimulus(S_IDLE, 1'b0, 1'b0, b, m, o, c);
    end
  endtask

  initial begin
    logic [1:0] rb, rm, ro;
    logic [3:0] rc;
    doReset();
    run_instr(2'b01, 2'b00, 2'b01, 4'h0, 1'b1, 1'b0);
    run_instr(2'b10, 2'b10, 2'b00, 4'h0, 1'b1, 1'b0);
    run_instr(2'b01, 2'b00, 2'b01, 4'hC, 1'b0, 1'b0);
    run_instr(2'b10, 2'b01, 2'b10, 4'h5, 1'b1, 1'b0);
    run_instr(2'b10, 2'b00, 2'b00, 4'h3, 1'b0, 1'b0);
    for (int n = 0; n < 30; n++) begin
      rb = ($urandom_range(0, 1) == 0) ? 2'b01 : 2'b10;
      rm = (rb == 2'b01) ? 2'b00 : 2'($urandom_range(0, 2));
      ro = 2'($urandom_range(0, 2));
      rc = ($urandom_range(0, 3) == 0) ? 4'hC : 4'($urandom);
      run_instr(rb, rm, ro, rc, 1'($urandom), 1'b0);
    end
    run_instr(2'b01, 2'b00, 2'b01, 4'h2, 1'b1, 1'b1);
    for (int n = 0; n < 5; n++) begin
      rb = 2'b10;
      rm = 2'($urandom_range(0, 2));
      ro = 2'($urandom_range(0, 2));
      run_instr(rb, rm, ro, 4'($urandom), 1'b1, 1'b0);
    end
    run_instr(2'b01, 2'b00, 2'b11, 4'h3, 1'b1, 1'b0);
    doReset();
    run_instr(2'b01, 2'b00, 2'b11, 4'hF, 1'b1, 1'b0);
    doReset();
    run_instr(2'b01, 2'b11, 2'b00, 4'h1, 1'b1, 1'b0);
    doReset();
    run_instr(2'b00, 2'b00, 2'b01, 4'h1, 1'b1, 1'b0);
    doReset();
    run_instr(2'b11, 2'b00, 2'b10, 4'h7, 1'b1, 1'b0);
    doReset();
    run_instr(2'b01, 2'b01, 2'b01, 4'h4, 1'b1, 1'b0);
    doReset();
    run_instr(2'b01, 2'b10, 2'b00, 4'h0, 1'b1, 1'b0);
    doReset();
    run_instr(2'b10, 2'b00, 2'b11, 4'hF, 1'b1, 1'b0);
    doReset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
